// File: rtl/cu_micro_sequencer.sv
// Control-unit micro-sequencer: latches one decoded instruction and issues base..base+ucnt addresses, one per cycle.
// Latency: the first micro-op is presented one cycle after its packet is accepted. Back-to-back packets add no bubble.
// Backpressure: while ex_ready is low, every output holds. cu_ready is high only when the current sequence is done.
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   flush_pipeline              aborts the current sequence and discards the incoming packet
//   dec_ready                   qualifies idecode_cu_interface; the packet is ignored while this is low
//   idecode_cu_interface[91:0]  {pred, branch_addr, addr_not_taken, micro_code, ucnt, uaddr, instr}
//   ex_ready                    downstream consumes the presented micro-op in this cycle
//   cu_ready                    combinational; this cycle can accept a new packet
//   uop_*                       presented micro-op, plus the instruction and branch fields latched with it
module cu_micro_sequencer #(
  parameter int                 UADDR_W  = 8,
  parameter int                 CNT_W    = 3,
  parameter logic [UADDR_W-1:0] NOP_ADDR = 8'hFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_pipeline,
  input  logic               dec_ready,
  input  logic [91:0]        idecode_cu_interface,
  input  logic               ex_ready,
  output logic               cu_ready,
  output logic               uop_valid,
  output logic [UADDR_W-1:0] uop_addr,
  output logic               uop_last,
  output logic [31:0]        uop_instr,
  output logic [7:0]         uop_addr_not_taken,
  output logic [7:0]         uop_branch_addr,
  output logic               uop_branch_pred
);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;

  // Packet field unpacking
  logic [31:0]        pkt_instr;
  logic [UADDR_W-1:0] pkt_uaddr;
  logic [CNT_W-1:0]   pkt_ucnt;
  logic [7:0]         pkt_not_taken;
  logic [7:0]         pkt_branch_addr;
  logic               pkt_branch_pred;
  logic               unused_micro_code;

  assign pkt_instr         = idecode_cu_interface[31:0];
  assign pkt_uaddr         = idecode_cu_interface[32 +: UADDR_W];
  assign pkt_ucnt          = idecode_cu_interface[40 +: CNT_W];
  assign pkt_not_taken     = idecode_cu_interface[82:75];
  assign pkt_branch_addr   = idecode_cu_interface[90:83];
  assign pkt_branch_pred   = idecode_cu_interface[91];
  // The micro_code field is carried by decode but has no consumer here.
  assign unused_micro_code = ^idecode_cu_interface[74:43];

  state_e             state_q, state_d;
  logic [UADDR_W-1:0] uop_addr_q, uop_addr_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic               uop_last_q, uop_last_d;
  logic [31:0]        instr_q, instr_d;
  logic [7:0]         not_taken_q, not_taken_d;
  logic [7:0]         branch_addr_q, branch_addr_d;
  logic               branch_pred_q, branch_pred_d;

  logic done;
  logic accept;
  logic advance;

  // The sequence is finished when nothing is presented, or when its last
  // micro-op is consumed in this cycle. That makes back-to-back issue possible.
  assign done     = (state_q == IDLE) | (uop_last_q & ex_ready);
  assign cu_ready = ~rst & ~flush_pipeline & done;
  assign accept   = cu_ready & dec_ready & (pkt_uaddr != NOP_ADDR);
  assign advance  = (state_q == ISSUE) & ex_ready & ~uop_last_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      uop_addr_q    <= NOP_ADDR;
      remaining_q   <= '0;
      uop_last_q    <= 1'b0;
      instr_q       <= '0;
      not_taken_q   <= '0;
      branch_addr_q <= '0;
      branch_pred_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      uop_addr_q    <= uop_addr_d;
      remaining_q   <= remaining_d;
      uop_last_q    <= uop_last_d;
      instr_q       <= instr_d;
      not_taken_q   <= not_taken_d;
      branch_addr_q <= branch_addr_d;
      branch_pred_q <= branch_pred_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush_pipeline) begin
      state_d = IDLE;
    end else if (accept) begin
      state_d = ISSUE;
    end else if ((state_q == ISSUE) && ex_ready && uop_last_q) begin
      state_d = IDLE;
    end
  end

  // Datapath next values. Flush takes priority over accept and over advance.
  always_comb begin
    uop_addr_d    = uop_addr_q;
    remaining_d   = remaining_q;
    uop_last_d    = uop_last_q;
    instr_d       = instr_q;
    not_taken_d   = not_taken_q;
    branch_addr_d = branch_addr_q;
    branch_pred_d = branch_pred_q;
    if (flush_pipeline) begin
      uop_addr_d  = NOP_ADDR;
      remaining_d = '0;
      uop_last_d  = 1'b0;
    end else if (accept) begin
      uop_addr_d    = pkt_uaddr;
      remaining_d   = pkt_ucnt;
      uop_last_d    = (pkt_ucnt == '0);
      instr_d       = pkt_instr;
      not_taken_d   = pkt_not_taken;
      branch_addr_d = pkt_branch_addr;
      branch_pred_d = pkt_branch_pred;
    end else if (advance) begin
      // Address arithmetic wraps modulo 2^UADDR_W.
      uop_addr_d  = uop_addr_q + UADDR_W'(1);
      remaining_d = remaining_q - CNT_W'(1);
      uop_last_d  = (remaining_q == CNT_W'(1));
    end else if ((state_q == ISSUE) && ex_ready && uop_last_q) begin
      uop_addr_d  = NOP_ADDR;
      remaining_d = '0;
      uop_last_d  = 1'b0;
    end
  end

  // Outputs
  always_comb begin
    uop_valid          = (state_q == ISSUE);
    uop_addr           = uop_addr_q;
    uop_last           = uop_last_q;
    uop_instr          = instr_q;
    uop_addr_not_taken = not_taken_q;
    uop_branch_addr    = branch_addr_q;
    uop_branch_pred    = branch_pred_q;
  end

endmodule
